// File: rtl/fetch_align_if.sv
// Handshake bundle between the prefetch FIFO, the fetch aligner and the decoder.
// The master side drives the FIFO head and decode acceptance; the slave side is the aligner.
interface fetch_align_if;
    logic        pr_reset;
    logic [67:0] prefetchfifo_accept_data;
    logic        prefetchfifo_accept_empty;
    logic        prefetchfifo_accept_do;
    logic [3:0]  dec_acceptable;
    logic [3:0]  fetch_valid;
    logic [63:0] fetch;
    logic        fetch_limit;
    logic        fetch_page_fault;

    modport master (
        output pr_reset, prefetchfifo_accept_data, prefetchfifo_accept_empty, dec_acceptable,
        input  prefetchfifo_accept_do, fetch_valid, fetch, fetch_limit, fetch_page_fault
    );

    modport slave (
        input  pr_reset, prefetchfifo_accept_data, prefetchfifo_accept_empty, dec_acceptable,
        output prefetchfifo_accept_do, fetch_valid, fetch, fetch_limit, fetch_page_fault
    );
endinterface

// File: rtl/fetch_align.sv
// Aligns prefetched 8-byte lines to the decoder, tracking a byte offset and sticky limit/fault markers.
// Define FETCH_ALIGN_LINE_REG_EN to source lines from a registered buffer instead of the FIFO head.
module fetch_align (
    input  logic          clk,
    input  logic          rst_n,
    fetch_align_if.slave  bus
);
    typedef enum logic [1:0] {RUN, LIMIT, PF} state_t;

    state_t      state_q, state_d;
    logic [2:0]  offset_q, offset_d;

    logic        src_vld;
    logic [67:0] src;
    logic [3:0]  len;
    logic [63:0] line_bytes;
    logic        active, run_src;
    logic        is_data, is_lim, is_pf;
    logic [3:0]  avail, taken;
    logic        data_rel, consume;
    logic [63:0] shifted;

    function automatic logic [63:0] byte_mask(input logic [3:0] n);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < n) m[i*8 +: 8] = 8'hFF;
        end
        return m;
    endfunction

`ifdef FETCH_ALIGN_LINE_REG_EN
    logic [67:0] line_q, line_d;
    logic        line_vld_q, line_vld_d;
    logic        load;

    assign src_vld = line_vld_q;
    assign src     = line_q;
`else
    assign src_vld = ~bus.prefetchfifo_accept_empty;
    assign src     = bus.prefetchfifo_accept_data;
`endif

    assign len        = src[67:64];
    assign line_bytes = src[63:0];
    assign active     = rst_n & ~bus.pr_reset;
    assign run_src    = active & (state_q == RUN) & src_vld;
    assign is_data    = (len >= 4'd1) && (len <= 4'd8);
    assign is_lim     = (len == 4'hE);
    assign is_pf      = (len == 4'hF);

    assign avail    = (run_src && is_data && ({1'b0, offset_q} < len)) ? (len - {1'b0, offset_q}) : 4'd0;
    assign taken    = (avail < bus.dec_acceptable) ? avail : bus.dec_acceptable;
    assign data_rel = run_src & is_data & (({1'b0, offset_q} + taken) == len);
    // Markers and malformed lengths are consumed immediately; data lines only when fully taken.
    assign consume  = run_src & (~is_data | data_rel);

    assign shifted = line_bytes >> {offset_q, 3'b000};

    assign bus.fetch_valid      = avail;
    assign bus.fetch            = shifted & byte_mask(avail);
    assign bus.fetch_limit      = active & (state_q == LIMIT);
    assign bus.fetch_page_fault = active & (state_q == PF);

`ifdef FETCH_ALIGN_LINE_REG_EN
    // Refill on a data/junk release, but not on a marker: the FSM stops popping once it leaves RUN.
    assign load = active & (state_q == RUN) & ~bus.prefetchfifo_accept_empty
                & (~line_vld_q | (consume & ~is_lim & ~is_pf));
    assign bus.prefetchfifo_accept_do = load;

    always_comb begin
        line_d     = line_q;
        line_vld_d = line_vld_q;
        if (bus.pr_reset) begin
            line_vld_d = 1'b0;
        end else if (load) begin
            line_d     = bus.prefetchfifo_accept_data;
            line_vld_d = 1'b1;
        end else if (consume) begin
            line_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) line_vld_q <= 1'b0;
        else        line_vld_q <= line_vld_d;
    end

    always_ff @(posedge clk) begin
        line_q <= line_d;
    end
`else
    assign bus.prefetchfifo_accept_do = consume;
`endif

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        if (bus.pr_reset) begin
            state_d  = RUN;
            offset_d = 3'd0;
        end else if (run_src) begin
            if (is_lim)       state_d  = LIMIT;
            else if (is_pf)   state_d  = PF;
            else if (is_data) offset_d = data_rel ? 3'd0 : (offset_q + taken[2:0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            offset_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
        end
    end
endmodule

// File: tb/tb_fetch_align.sv
// Self-checking bench for fetch_align: directed scenarios followed by random traffic against a byte-level model.
module tb_fetch_align;
    logic clk;
    logic rst_n;
    fetch_align_if bus ();

    fetch_align dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [67:0] fifo [$];
    int m_off = 0;
    int m_st  = 0;   // 0 = RUN, 1 = LIMIT, 2 = PF

    function automatic logic [67:0] mk(input logic [3:0] l, input logic [63:0] b);
        return {l, b};
    endfunction

    function automatic logic [67:0] rand_entry();
        int r;
        logic [3:0] l;
        r = $urandom_range(0, 99);
        if (r < 80)      l = 4'($urandom_range(1, 8));
        else if (r < 90) l = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 13));
        else if (r < 95) l = 4'hE;
        else             l = 4'hF;
        return {l, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fv"},    64'(bus.fetch_valid), 64'd0);
        chk({tag, "_fetch"}, bus.fetch, 64'd0);
        chk({tag, "_pop"},   64'(bus.prefetchfifo_accept_do), 64'd0);
        chk({tag, "_lim"},   64'(bus.fetch_limit), 64'd0);
        chk({tag, "_pf"},    64'(bus.fetch_page_fault), 64'd0);
    endtask

    // One clock: drive at the falling edge, check mid-cycle, update the model at the rising edge.
    task automatic cycle(input logic [3:0] dec, input bit prr, input bit hide);
        logic [67:0] h;
        logic [63:0] ef;
        bit emp, ep;
        int len, fv, tk;
        emp = hide || (fifo.size() == 0);
        h   = (fifo.size() != 0) ? fifo[0] : {4'($urandom), $urandom, $urandom};
        bus.prefetchfifo_accept_data  = h;
        bus.prefetchfifo_accept_empty = emp;
        bus.dec_acceptable            = dec;
        bus.pr_reset                  = prr;
        #1;
        fv = 0; tk = 0; ef = '0; ep = 1'b0; len = 0;
        if (!prr && m_st == 0 && !emp) begin
            len = int'(h[67:64]);
            if (len >= 1 && len <= 8) begin
                fv = len - m_off;
                for (int j = 0; j < fv; j++) ef[8*j +: 8] = h[8*(m_off+j) +: 8];
                tk = (fv < int'(dec)) ? fv : int'(dec);
                ep = (m_off + tk == len);
            end else begin
                ep = 1'b1;
            end
        end
        chk("fetch_valid", 64'(bus.fetch_valid), 64'(fv));
        chk("fetch", bus.fetch, ef);
        chk("pop", 64'(bus.prefetchfifo_accept_do), 64'(ep));
        chk("limit", 64'(bus.fetch_limit), 64'(!prr && m_st == 1));
        chk("page_fault", 64'(bus.fetch_page_fault), 64'(!prr && m_st == 2));
        @(posedge clk);
        if (prr) begin
            m_off = 0; m_st = 0;
            fifo.delete();
        end else if (ep) begin
            if (len == 14) m_st = 1;
            else if (len == 15) m_st = 2;
            m_off = 0;
            void'(fifo.pop_front());
        end else begin
            m_off += tk;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.pr_reset = 1'b0;
        bus.dec_acceptable = 4'd8;
        bus.prefetchfifo_accept_empty = 1'b0;
        bus.prefetchfifo_accept_data = mk(4'd8, 64'h1122334455667788);
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Partial consumption of an 8-byte line, then release.
        fifo.push_back(mk(4'd8, 64'h0706050403020100));
        cycle(4'd3, 1'b0, 1'b0);
        cycle(4'd5, 1'b0, 1'b0);

        // Short line: bytes beyond len must not leak into fetch.
        fifo.push_back(mk(4'd2, 64'hFFEEDDCCBBAA9988));
        cycle(4'd8, 1'b0, 1'b0);

        // FIFO reports empty for four cycles mid-line.
        fifo.push_back(mk(4'd6, 64'h0123456789ABCDEF));
        cycle(4'd2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(4'd8, 1'b0, 1'b1);
        cycle(4'd8, 1'b0, 1'b0);

        // Limit marker after a data line, held for ten cycles, cleared by pr_reset.
        fifo.push_back(mk(4'd3, 64'h0000000000CAFE01));
        fifo.push_back(mk(4'hE, 64'hDEADBEEFDEADBEEF));
        fifo.push_back(mk(4'd4, 64'h55AA55AA55AA55AA));
        cycle(4'd8, 1'b0, 1'b0);
        cycle(4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(4'd8, 1'b0, 1'b0);
        cycle(4'd8, 1'b1, 1'b0);
        fifo.push_back(mk(4'd4, 64'h00000000A1B2C3D4));
        cycle(4'd8, 1'b0, 1'b0);

        // Page-fault marker.
        fifo.push_back(mk(4'hF, 64'h0));
        fifo.push_back(mk(4'd1, 64'h77));
        for (int i = 0; i < 4; i++) cycle(4'd8, 1'b0, 1'b0);
        cycle(4'd8, 1'b1, 1'b0);

        // Malformed lengths are dropped silently.
        fifo.push_back(mk(4'd0, 64'h1));
        fifo.push_back(mk(4'd9, 64'h2));
        fifo.push_back(mk(4'd13, 64'h3));
        fifo.push_back(mk(4'd5, 64'h000000FEDCBA9876));
        for (int i = 0; i < 4; i++) cycle(4'd8, 1'b0, 1'b0);

        // pr_reset coinciding with a releasing consumption.
        fifo.push_back(mk(4'd4, 64'h00000000CCDDEEFF));
        fifo.push_back(mk(4'd8, 64'h1111111111111111));
        cycle(4'd8, 1'b1, 1'b0);
        fifo.push_back(mk(4'd5, 64'h0000003132333435));
        cycle(4'd8, 1'b0, 1'b0);

        // Asynchronous reset mid-line at offset 5.
        fifo.push_back(mk(4'd8, 64'h8877665544332211));
        cycle(4'd5, 1'b0, 1'b0);
        bus.dec_acceptable = 4'd8;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        m_off = 0; m_st = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'd8, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            bit prr;
            while (fifo.size() < 3) fifo.push_back(rand_entry());
            prr = (m_st != 0 && $urandom_range(0, 3) == 0) || ($urandom_range(0, 40) == 0);
            cycle(4'($urandom_range(0, 8)), prr, $urandom_range(0, 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
